riot_port_arbiter: RTL and testbench

- Shares the single bus port of the M6532 RIOT between the 6502 CPU, which has absolute priority, and an auxiliary requester such as a savestate or debug engine.
- The aux requester gets read and write access to RIOT RAM and registers, but only in PHI2 slots (ce=1) where the CPU is not selecting the RIOT.
- Sits between the system address decoder and the M6532 instance, driving all of the RIOT's bus inputs.

---
 rtl/riot_arb_pkg.sv | 19 +
 rtl/riot_bus_mux.sv | 30 +++
 rtl/riot_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_riot_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riot_arb_pkg.sv
// Shared types and helpers for the RIOT bus-port arbiter.
package riot_arb_pkg;

    localparam int RIOT_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

    // Reads of the timer/interrupt space clear interrupt flags inside the RIOT.
    function automatic logic is_side_read(input logic                   rs_n,
                                          input logic [RIOT_ADDR_W-1:0] addr,
                                          input logic                   rw_n);
        return rs_n & addr[2] & rw_n;
    endfunction

endpackage

// File: rtl/riot_bus_mux.sv
// Combinational selector feeding the RIOT bus from either the CPU or the latched aux request.
module riot_bus_mux
    import riot_arb_pkg::*;
(
    input  logic                   grant_i,
    input  logic                   cpu_sel_i,
    input  logic [RIOT_ADDR_W-1:0] cpu_addr_i,
    input  logic                   cpu_rs_n_i,
    input  logic                   cpu_rw_n_i,
    input  logic [7:0]             cpu_wdata_i,
    input  logic [RIOT_ADDR_W-1:0] aux_addr_i,
    input  logic                   aux_rs_n_i,
    input  logic                   aux_rw_n_i,
    input  logic [7:0]             aux_wdata_i,
    output logic [RIOT_ADDR_W-1:0] riot_addr_o,
    output logic                   riot_rw_n_o,
    output logic [7:0]             riot_din_o,
    output logic                   riot_rs_n_o,
    output logic                   riot_cs1_o,
    output logic                   riot_cs2_n_o
);

    assign riot_addr_o  = grant_i ? aux_addr_i  : cpu_addr_i;
    assign riot_rw_n_o  = grant_i ? aux_rw_n_i  : cpu_rw_n_i;
    assign riot_din_o   = grant_i ? aux_wdata_i : cpu_wdata_i;
    assign riot_rs_n_o  = grant_i ? aux_rs_n_i  : cpu_rs_n_i;
    assign riot_cs1_o   = grant_i | cpu_sel_i;
    assign riot_cs2_n_o = ~(grant_i | cpu_sel_i);

endmodule

// File: rtl/riot_port_arbiter.sv
// Shares the M6532 bus port between the CPU (absolute priority) and an aux requester.
// Optional slot timeout enabled by defining RIOT_ARB_TIMEOUT_EN.
module riot_port_arbiter
    import riot_arb_pkg::*;
#(
    parameter bit          ALLOW_SIDE_READ = 1'b0,
    parameter int unsigned TIMEOUT_SLOTS   = 255
)(
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   ce,
    input  logic                   cpu_sel,
    input  logic [RIOT_ADDR_W-1:0] cpu_addr,
    input  logic                   cpu_rs_n,
    input  logic                   cpu_rw_n,
    input  logic [7:0]             cpu_wdata,
    input  logic                   aux_req,
    input  logic [RIOT_ADDR_W-1:0] aux_addr,
    input  logic                   aux_rs_n,
    input  logic                   aux_rw_n,
    input  logic [7:0]             aux_wdata,
    output logic                   aux_busy,
    output logic                   aux_ack,
    output logic                   aux_err,
    output logic [7:0]             aux_rdata,
    output logic [RIOT_ADDR_W-1:0] riot_addr,
    output logic                   riot_rw_n,
    output logic [7:0]             riot_din,
    output logic                   riot_rs_n,
    output logic                   riot_cs1,
    output logic                   riot_cs2_n,
    input  logic [7:0]             riot_dout
);

    arb_state_e             state_q, state_d;
    logic [RIOT_ADDR_W-1:0] addr_q, addr_d;
    logic                   rs_n_q, rs_n_d;
    logic                   rw_n_q, rw_n_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   grant;
    logic                   timeout_hit;

    assign grant = (state_q == WAIT) & ce & ~cpu_sel;

`ifdef RIOT_ARB_TIMEOUT_EN
    logic [7:0] slot_q, slot_d;

    // A grant in the same cycle as the limit takes precedence over the abort.
    assign timeout_hit = (state_q == WAIT) & ~grant & (slot_q == 8'(TIMEOUT_SLOTS));

    always_comb begin
        slot_d = slot_q;
        if (state_q != WAIT) begin
            slot_d = 8'd0;
        end else if (ce && cpu_sel) begin
            slot_d = slot_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) slot_q <= 8'd0;
        else        slot_q <= slot_d;
    end
`else
    logic [7:0] unused_timeout_slots;
    assign unused_timeout_slots = 8'(TIMEOUT_SLOTS);
    assign timeout_hit          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rs_n_d  = rs_n_q;
        rw_n_d  = rw_n_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (aux_req) begin
                    addr_d  = aux_addr;
                    rs_n_d  = aux_rs_n;
                    rw_n_d  = aux_rw_n;
                    wdata_d = aux_wdata;
                    if (!ALLOW_SIDE_READ && is_side_read(aux_rs_n, aux_addr, aux_rw_n)) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (grant) begin
                    if (rw_n_q) begin
                        state_d = CAPTURE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                // riot_dout still holds the grant-edge value; a CPU access now updates it only afterwards.
                rdata_d = riot_dout;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rs_n_q  <= 1'b0;
            rw_n_q  <= 1'b0;
            wdata_q <= 8'h00;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rs_n_q  <= rs_n_d;
            rw_n_q  <= rw_n_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign aux_busy  = (state_q != IDLE);
    assign aux_ack   = ack_q;
    assign aux_err   = err_q;
    assign aux_rdata = rdata_q;

    riot_bus_mux u_bus_mux (
        .grant_i      (grant),
        .cpu_sel_i    (cpu_sel),
        .cpu_addr_i   (cpu_addr),
        .cpu_rs_n_i   (cpu_rs_n),
        .cpu_rw_n_i   (cpu_rw_n),
        .cpu_wdata_i  (cpu_wdata),
        .aux_addr_i   (addr_q),
        .aux_rs_n_i   (rs_n_q),
        .aux_rw_n_i   (rw_n_q),
        .aux_wdata_i  (wdata_q),
        .riot_addr_o  (riot_addr),
        .riot_rw_n_o  (riot_rw_n),
        .riot_din_o   (riot_din),
        .riot_rs_n_o  (riot_rs_n),
        .riot_cs1_o   (riot_cs1),
        .riot_cs2_n_o (riot_cs2_n)
    );

endmodule

// File: tb/tb_riot_port_arbiter.sv
// Directed self-checking bench for riot_port_arbiter with a small RIOT RAM/interrupt model.
module tb_riot_port_arbiter;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic [1:0] ce_cnt = 2'd0;
    logic       ce;
    logic       cpu_sel = 1'b0;
    logic [6:0] cpu_addr = 7'h00;
    logic       cpu_rs_n = 1'b0;
    logic       cpu_rw_n = 1'b1;
    logic [7:0] cpu_wdata = 8'h00;
    logic       aux_req = 1'b0;
    logic [6:0] aux_addr = 7'h00;
    logic       aux_rs_n = 1'b0;
    logic       aux_rw_n = 1'b1;
    logic [7:0] aux_wdata = 8'h00;
    logic       aux_busy, aux_ack, aux_err;
    logic [7:0] aux_rdata;
    logic [6:0] riot_addr;
    logic       riot_rw_n, riot_rs_n, riot_cs1, riot_cs2_n;
    logic [7:0] riot_din;
    logic [7:0] riot_dout = 8'h00;

    int checks = 0;
    int errors = 0;

    // RIOT model state
    logic [7:0] ram [128] = '{default: 8'h00};
    logic [7:0] irq_flags = 8'h40;
    int         aux_acc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
    assign ce = (ce_cnt == 2'd3);

    always @(posedge clk) begin
        if (ce && riot_cs1 && !riot_cs2_n) begin
            if (!riot_rs_n) begin
                if (riot_rw_n) riot_dout <= ram[riot_addr];
                else           ram[riot_addr] <= riot_din;
            end else if (riot_addr[2] && riot_rw_n) begin
                riot_dout    <= irq_flags;
                irq_flags[6] <= 1'b0;
            end
        end
        if (ce && riot_cs1 && !cpu_sel) aux_acc_cnt <= aux_acc_cnt + 1;
    end

    riot_port_arbiter #(.ALLOW_SIDE_READ(1'b0), .TIMEOUT_SLOTS(4)) dut (
        .clk(clk), .res_n(res_n), .ce(ce), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
        .cpu_rs_n(cpu_rs_n), .cpu_rw_n(cpu_rw_n), .cpu_wdata(cpu_wdata),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_rs_n(aux_rs_n), .aux_rw_n(aux_rw_n),
        .aux_wdata(aux_wdata), .aux_busy(aux_busy), .aux_ack(aux_ack), .aux_err(aux_err),
        .aux_rdata(aux_rdata), .riot_addr(riot_addr), .riot_rw_n(riot_rw_n),
        .riot_din(riot_din), .riot_rs_n(riot_rs_n), .riot_cs1(riot_cs1),
        .riot_cs2_n(riot_cs2_n), .riot_dout(riot_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic rs, input logic rw, input logic [7:0] d);
        aux_req = 1'b1; aux_addr = a; aux_rs_n = rs; aux_rw_n = rw; aux_wdata = d;
        tick();
        aux_req = 1'b0;
    endtask

    // Returns the number of cycles waited, or -1 if no ack arrived within the budget.
    task automatic wait_ack(input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (aux_ack) begin cyc = i; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        res_n = 1'b0; cpu_sel = 1'b1; cpu_addr = 7'h55; cpu_rs_n = 1'b0; cpu_rw_n = 1'b1; cpu_wdata = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({aux_busy, aux_ack, aux_err} !== 3'b000 || aux_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: busy/ack/err=%b rdata=%h, want 000 / 00", {aux_busy, aux_ack, aux_err}, aux_rdata);
        end
        checks++;
        if (riot_cs1 !== 1'b1 || riot_cs2_n !== 1'b0 || riot_addr !== 7'h55 || riot_din !== 8'h77 || riot_rw_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_cpu_path: cs1=%b cs2_n=%b addr=%h din=%h rw=%b, want 1 0 55 77 1", riot_cs1, riot_cs2_n, riot_addr, riot_din, riot_rw_n);
        end
        @(negedge clk);
        res_n = 1'b1; cpu_sel = 1'b0;
        tick();
        checks++;
        if ({aux_busy, aux_ack, aux_err} !== 3'b000 || riot_cs1 !== 1'b0 || riot_cs2_n !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: busy/ack/err=%b cs1=%b cs2_n=%b, want 000 0 1", {aux_busy, aux_ack, aux_err}, riot_cs1, riot_cs2_n);
        end
    endtask

    task automatic test_idle_write();
        logic found, bad_early;
        int   c;
        cpu_sel = 1'b0;
        issue(7'h10, 1'b0, 1'b0, 8'hA5);
        checks++;
        if (aux_busy !== 1'b1 || aux_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_busy: busy=%b ack=%b, want 1 0", aux_busy, aux_ack);
        end
        found = 1'b0; bad_early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ce) begin found = 1'b1; break; end
            if (riot_cs1 !== 1'b0) bad_early = 1'b1;
            tick();
        end
        checks++;
        if (!found || bad_early || riot_cs1 !== 1'b1 || riot_cs2_n !== 1'b0 || riot_din !== 8'hA5 ||
            riot_addr !== 7'h10 || riot_rw_n !== 1'b0 || riot_rs_n !== 1'b0) begin
            errors++;
            $display("FAIL write_grant: found=%b early=%b cs1=%b din=%h addr=%h rw=%b rs=%b, want 1 0 1 a5 10 0 0",
                     found, bad_early, riot_cs1, riot_din, riot_addr, riot_rw_n, riot_rs_n);
        end
        tick();
        checks++;
        if (aux_ack !== 1'b1 || aux_err !== 1'b0 || aux_busy !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: ack=%b err=%b busy=%b, want 1 0 0", aux_ack, aux_err, aux_busy);
        end
        tick();
        checks++;
        if (aux_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack=%b, want 0", aux_ack);
        end
        issue(7'h10, 1'b0, 1'b1, 8'h00);
        wait_ack(50, c);
        checks++;
        if (c < 0 || aux_err !== 1'b0 || aux_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL write_readback: waited=%0d err=%b rdata=%h, want ack err=0 a5", c, aux_err, aux_rdata);
        end
        tick();
    endtask

    task automatic test_contention_read();
        int         c, slot;
        logic       cpu_ok, granted, g_rw;
        logic [6:0] g_addr;
        issue(7'h10, 1'b0, 1'b0, 8'h3C);
        wait_ack(50, c);
        checks++;
        if (c < 0 || aux_err !== 1'b0) begin
            errors++;
            $display("FAIL preload_write: waited=%0d err=%b, want ack err=0", c, aux_err);
        end
        tick();
        cpu_sel = 1'b1; cpu_addr = 7'h20; cpu_rs_n = 1'b0; cpu_rw_n = 1'b1;
        issue(7'h10, 1'b0, 1'b1, 8'h00);
        slot = 0; cpu_ok = 1'b1; granted = 1'b0; g_addr = 7'h00; g_rw = 1'b0;
        for (int i = 0; i < 64 && !granted; i++) begin
            if (slot == 3) cpu_sel = 1'b0;
            #1;
            if (ce) begin
                slot++;
                if (slot <= 3) begin
                    if (riot_addr !== 7'h20 || riot_cs1 !== 1'b1 || aux_busy !== 1'b1) cpu_ok = 1'b0;
                end else begin
                    granted = 1'b1; g_addr = riot_addr; g_rw = riot_rw_n;
                end
            end
            if (!granted) tick();
        end
        checks++;
        if (!cpu_ok) begin
            errors++;
            $display("FAIL cpu_priority: cpu lost the bus during a contended slot");
        end
        checks++;
        if (!granted || slot != 4 || g_addr !== 7'h10 || g_rw !== 1'b1) begin
            errors++;
            $display("FAIL contention_grant: granted=%b slot=%0d addr=%h rw=%b, want 1 4 10 1", granted, slot, g_addr, g_rw);
        end
        tick();
        checks++;
        if (aux_busy !== 1'b1 || aux_ack !== 1'b0) begin
            errors++;
            $display("FAIL capture_cycle: busy=%b ack=%b, want 1 0", aux_busy, aux_ack);
        end
        tick();
        checks++;
        if (aux_ack !== 1'b1 || aux_err !== 1'b0 || aux_rdata !== 8'h3C || aux_busy !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: ack=%b err=%b rdata=%h busy=%b, want 1 0 3c 0", aux_ack, aux_err, aux_rdata, aux_busy);
        end
        tick();
    endtask

    task automatic test_refusal();
        int acc0, c;
        cpu_sel = 1'b0;
        acc0 = aux_acc_cnt;
        issue(7'h05, 1'b1, 1'b1, 8'h00);
        checks++;
        if (aux_ack !== 1'b1 || aux_err !== 1'b1 || aux_busy !== 1'b0) begin
            errors++;
            $display("FAIL refusal_ack: ack=%b err=%b busy=%b, want 1 1 0", aux_ack, aux_err, aux_busy);
        end
        repeat (8) tick();
        checks++;
        if (aux_acc_cnt != acc0 || irq_flags[6] !== 1'b1 || aux_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL refusal_no_access: accesses=%0d irq6=%b rdata=%h, want %0d 1 3c", aux_acc_cnt, irq_flags[6], aux_rdata, acc0);
        end
        issue(7'h14, 1'b1, 1'b0, 8'h81);
        wait_ack(50, c);
        checks++;
        if (c < 0 || aux_err !== 1'b0 || aux_acc_cnt != acc0 + 1) begin
            errors++;
            $display("FAIL side_write: waited=%0d err=%b accesses=%0d, want ack 0 %0d", c, aux_err, aux_acc_cnt, acc0 + 1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int c;
        issue(7'h11, 1'b0, 1'b0, 8'h5A);
        wait_ack(50, c);
        aux_req = 1'b1; aux_addr = 7'h05; aux_rs_n = 1'b1; aux_rw_n = 1'b1;
        tick();
        aux_req = 1'b0;
        checks++;
        if (c < 0 || aux_ack !== 1'b1 || aux_err !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: waited=%0d ack=%b err=%b, want ack 1 1", c, aux_ack, aux_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        int   slots, acc0, c;
        logic got, ok;
        cpu_sel = 1'b1; cpu_addr = 7'h20; cpu_rs_n = 1'b0; cpu_rw_n = 1'b1;
        acc0 = aux_acc_cnt;
        issue(7'h10, 1'b0, 1'b1, 8'h00);
`ifdef RIOT_ARB_TIMEOUT_EN
        slots = 0; got = 1'b0; ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (aux_ack) begin got = 1'b1; break; end
            if (ce && aux_busy) slots++;
            tick();
        end
        checks++;
        if (!got || aux_err !== 1'b1 || slots != 4) begin
            errors++;
            $display("FAIL timeout_abort: ack=%b err=%b slots=%0d, want 1 1 4", got, aux_err, slots);
        end
        checks++;
        if (aux_acc_cnt != acc0 || aux_rdata !== 8'h3C || !ok) begin
            errors++;
            $display("FAIL timeout_no_access: accesses=%0d rdata=%h, want %0d 3c", aux_acc_cnt, aux_rdata, acc0);
        end
        cpu_sel = 1'b0;
        c = 0;
        tick();
`else
        slots = 0; ok = 1'b1; got = 1'b0;
        for (int i = 0; i < 4100 && slots < 1000; i++) begin
            if (aux_ack || !aux_busy) ok = 1'b0;
            if (ce && aux_busy) slots++;
            tick();
        end
        checks++;
        if (!ok || slots != 1000 || aux_busy !== 1'b1 || aux_acc_cnt != acc0) begin
            errors++;
            $display("FAIL no_timeout_hold: ok=%b slots=%0d busy=%b accesses=%0d, want 1 1000 1 %0d", ok, slots, aux_busy, aux_acc_cnt, acc0);
        end
        cpu_sel = 1'b0;
        wait_ack(50, c);
        checks++;
        if (c < 0 || aux_err !== 1'b0 || aux_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL hold_then_grant: waited=%0d err=%b rdata=%h, want ack 0 3c", c, aux_err, aux_rdata);
        end
        tick();
`endif
    endtask

    task automatic test_reset_midread();
        logic found, seen;
        int   c;
        cpu_sel = 1'b0;
        issue(7'h10, 1'b0, 1'b1, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ce) begin found = 1'b1; break; end
            tick();
        end
        tick();
        checks++;
        if (!found || aux_busy !== 1'b1 || aux_ack !== 1'b0) begin
            errors++;
            $display("FAIL midread_capture: found=%b busy=%b ack=%b, want 1 1 0", found, aux_busy, aux_ack);
        end
        res_n = 1'b0;
        #1;
        checks++;
        if ({aux_busy, aux_ack, aux_err} !== 3'b000 || aux_rdata !== 8'h00 || riot_cs1 !== 1'b0 || riot_cs2_n !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: busy/ack/err=%b rdata=%h cs1=%b cs2_n=%b, want 000 00 0 1",
                     {aux_busy, aux_ack, aux_err}, aux_rdata, riot_cs1, riot_cs2_n);
        end
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (aux_ack || aux_busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL dropped_request: ack/busy=1 after reset release, want 0");
        end
        issue(7'h10, 1'b0, 1'b1, 8'h00);
        wait_ack(50, c);
        checks++;
        if (c < 0 || aux_err !== 1'b0 || aux_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL post_reset_read: waited=%0d err=%b rdata=%h, want ack 0 3c", c, aux_err, aux_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_write();
        test_contention_read();
        test_refusal();
        test_back_to_back();
        test_timeout();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
